// File: rtl/rtype_sequencer.sv
// rtype_sequencer: control sequencer for the register-type instruction flow
// of a simple bus-based datapath. Fetches the instruction (T0..T2), checks it,
// then steps the datapath through read-operands / ALU / write-back states.
//
// Handshake: a request is accepted only when start=1 is sampled in IDLE or in
// DONE (back-to-back). While busy=1 in any other state, start is ignored.
// Completion is reported by a one-cycle done (DONE state), a one-cycle illegal
// (T3 of a rejected instruction) or a one-cycle timeout (first IDLE cycle
// after the memory wait budget ran out). Exactly one of these ends each run.
//
// Ports:
//   Clock        rising-edge clock
//   clear        synchronous active-low reset
//   start        request to run one instruction
//   ir[31:0]     datapath IR (opcode/Ra/Rb/Rc), must be stable T3..DONE
//   mem_rdy      memory read data valid, sampled in T1
//   PCout..HIin  datapath strobes
//   regout/regin one-hot register bus enables (NREGS wide)
//   operation    ALU opcode, 0 unless the ALU is being driven
//   busy, done, illegal, timeout  status
module rtype_sequencer #(
  parameter int NREGS    = 16,
  parameter int WAIT_MAX = 15,
  parameter int HILO_EN  = 1
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             LOin,
  output logic             HIin,
  output logic [NREGS-1:0] regout,
  output logic [NREGS-1:0] regin,
  output logic [4:0]       operation,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  // Counter holds the number of mem_rdy=0 cycles already spent in T1.
  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0]    WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [4:0]       NREGS_L   = 5'(NREGS);
  localparam logic [NREGS-1:0] ONE       = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic             HILO_OK   = (HILO_EN != 0);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          timeout_q;

  // Instruction fields and classification
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_hilo, is_un;
  logic       ra_bad, rb_bad, rc_bad, legal;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_bin  = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_hilo = (opcode == 5'd15) || (opcode == 5'd16);
  assign is_un   = (opcode == 5'd17) || (opcode == 5'd18);

  assign ra_bad = ({1'b0, ra} >= NREGS_L);
  assign rb_bad = ({1'b0, rb} >= NREGS_L);
  assign rc_bad = ({1'b0, rc} >= NREGS_L);

  // HILO results land in LO/HI, so Ra is not a used index there; unary
  // instructions have no Rc operand.
  assign legal = (is_bin  && !ra_bad && !rb_bad && !rc_bad) ||
                 (is_hilo && HILO_OK && !rb_bad && !rc_bad) ||
                 (is_un   && !ra_bad && !rb_bad);

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          wait_cnt <= '0;
        end
        S_T1: begin
          if (mem_rdy) begin
            state <= S_T2;
          end else if (wait_cnt == WAIT_LAST) begin
            // Budget spent: abandon the fetch before any register write.
            state     <= S_IDLE;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_T2: state <= S_T3;
        S_T3: begin
          if (!legal)     state <= S_IDLE;
          else if (is_un) state <= S_T5;
          else            state <= S_T4;
        end
        S_T4: state <= S_T5;
        S_T5: state <= is_hilo ? S_T6 : S_DONE;
        S_T6: state <= S_DONE;
        S_DONE: state <= start ? S_T0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the strobes from state and ir
  always_comb begin
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    PCin      = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    regout    = '0;
    regin     = '0;
    operation = 5'd0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    timeout   = timeout_q;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (!legal) begin
          illegal = 1'b1;
        end else begin
          regout = ONE << rb;
          if (is_un) begin
            operation = opcode;
            Zin       = 1'b1;
          end else begin
            Yin = 1'b1;
          end
        end
      end
      S_T4: begin
        regout    = ONE << rc;
        operation = opcode;
        Zin       = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_hilo) LOin = 1'b1;
        else         regin = ONE << ra;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Testbench for rtype_sequencer. Two instances: the default configuration and
// a reduced one (NREGS=8, HILO_EN=0) for range / HILO rejection. Expected
// per-cycle output vectors are queued with their cycle number when stimulus
// is issued; a negedge monitor pops and compares them, and flags any DUT
// activity in a cycle that has no expectation.
module tb_rtype_sequencer;

  // ---------------- clock / reset ----------------
  logic Clock;
  logic clear;
  int   cyc;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  initial cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start, start8, mem_rdy;
  logic [31:0] ir;

  logic PCout0, MARin0, IncPC0, Zin0, Zlowout0, Zhighout0, PCin0, Read0;
  logic MDRin0, MDRout0, IRin0, Yin0, LOin0, HIin0;
  logic [15:0] regout0, regin0;
  logic [4:0]  operation0;
  logic        busy0, done0, illegal0, timeout0;

  logic PCout8, MARin8, IncPC8, Zin8, Zlowout8, Zhighout8, PCin8, Read8;
  logic MDRin8, MDRout8, IRin8, Yin8, LOin8, HIin8;
  logic [7:0]  regout8, regin8;
  logic [4:0]  operation8;
  logic        busy8, done8, illegal8, timeout8;

  rtype_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout0), .MARin(MARin0), .IncPC(IncPC0), .Zin(Zin0),
    .Zlowout(Zlowout0), .Zhighout(Zhighout0), .PCin(PCin0), .Read(Read0),
    .MDRin(MDRin0), .MDRout(MDRout0), .IRin(IRin0), .Yin(Yin0),
    .LOin(LOin0), .HIin(HIin0), .regout(regout0), .regin(regin0),
    .operation(operation0), .busy(busy0), .done(done0),
    .illegal(illegal0), .timeout(timeout0)
  );

  rtype_sequencer #(.NREGS(8), .WAIT_MAX(15), .HILO_EN(0)) dut8 (
    .Clock(Clock), .clear(clear), .start(start8), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout8), .MARin(MARin8), .IncPC(IncPC8), .Zin(Zin8),
    .Zlowout(Zlowout8), .Zhighout(Zhighout8), .PCin(PCin8), .Read(Read8),
    .MDRin(MDRin8), .MDRout(MDRout8), .IRin(IRin8), .Yin(Yin8),
    .LOin(LOin8), .HIin(HIin8), .regout(regout8), .regin(regin8),
    .operation(operation8), .busy(busy8), .done(done8),
    .illegal(illegal8), .timeout(timeout8)
  );

  // Vector layout: {strobes[13:0], regout[15:0], regin[15:0], op[4:0],
  //                 busy, done, illegal, timeout}
  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_MARIN  = 14'h1000;
  localparam logic [13:0] S_INCPC  = 14'h0800;
  localparam logic [13:0] S_ZIN    = 14'h0400;
  localparam logic [13:0] S_ZLOW   = 14'h0200;
  localparam logic [13:0] S_ZHIGH  = 14'h0100;
  localparam logic [13:0] S_PCIN   = 14'h0080;
  localparam logic [13:0] S_READ   = 14'h0040;
  localparam logic [13:0] S_MDRIN  = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010;
  localparam logic [13:0] S_IRIN   = 14'h0008;
  localparam logic [13:0] S_YIN    = 14'h0004;
  localparam logic [13:0] S_LOIN   = 14'h0002;
  localparam logic [13:0] S_HIIN   = 14'h0001;

  localparam int BIN  = 0;
  localparam int HILO = 1;
  localparam int UN   = 2;

  // ---------------- scoreboard ----------------
  logic [54:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_dut_q[$];
  string       exp_tag_q[$];
  int          n_checks;
  int          n_pass;

  task automatic push(input int c, input int d, input string tag,
                      input logic [13:0] s, input logic [15:0] ro,
                      input logic [15:0] ri, input logic [4:0] op,
                      input logic bz, input logic dn, input logic il,
                      input logic to);
    exp_q.push_back({s, ro, ri, op, bz, dn, il, to});
    exp_cyc_q.push_back(c);
    exp_dut_q.push_back(d);
    exp_tag_q.push_back(tag);
  endtask

  task automatic push_idle(input int c, input int d, input string tag);
    push(c, d, tag, 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // T0, T1 (1 + waits cycles), T2; returns the T3 cycle.
  task automatic push_front(input int d, input string tag, input int s,
                            input int waits, output int t3);
    push(s, d, {tag, "_t0"}, S_PCOUT | S_MARIN | S_INCPC | S_ZIN,
         16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= waits; k++)
      push(s + 1 + k, d, {tag, "_t1"}, S_ZLOW | S_PCIN | S_READ | S_MDRIN,
           16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(s + 2 + waits, d, {tag, "_t2"}, S_MDROUT | S_IRIN,
         16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    t3 = s + 3 + waits;
  endtask

  task automatic push_txn(input int d, input string tag, input int s,
                          input int cls, input int ra, input int rb,
                          input int rc, input logic [4:0] op,
                          input int waits, output int done_c);
    int t3;
    push_front(d, tag, s, waits, t3);
    if (cls == UN) begin
      push(t3, d, {tag, "_t3"}, S_ZIN, 16'h1 << rb, 16'h0, op,
           1'b1, 1'b0, 1'b0, 1'b0);
      push(t3 + 1, d, {tag, "_t5"}, S_ZLOW, 16'h0, 16'h1 << ra, 5'd0,
           1'b1, 1'b0, 1'b0, 1'b0);
      done_c = t3 + 2;
    end else begin
      push(t3, d, {tag, "_t3"}, S_YIN, 16'h1 << rb, 16'h0, 5'd0,
           1'b1, 1'b0, 1'b0, 1'b0);
      push(t3 + 1, d, {tag, "_t4"}, S_ZIN, 16'h1 << rc, 16'h0, op,
           1'b1, 1'b0, 1'b0, 1'b0);
      if (cls == HILO) begin
        push(t3 + 2, d, {tag, "_t5"}, S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'd0,
             1'b1, 1'b0, 1'b0, 1'b0);
        push(t3 + 3, d, {tag, "_t6"}, S_ZHIGH | S_HIIN, 16'h0, 16'h0, 5'd0,
             1'b1, 1'b0, 1'b0, 1'b0);
        done_c = t3 + 4;
      end else begin
        push(t3 + 2, d, {tag, "_t5"}, S_ZLOW, 16'h0, 16'h1 << ra, 5'd0,
             1'b1, 1'b0, 1'b0, 1'b0);
        done_c = t3 + 3;
      end
    end
    push(done_c, d, {tag, "_done"}, 14'h0, 16'h0, 16'h0, 5'd0,
         1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_illegal(input int d, input string tag, input int s);
    int t3;
    push_front(d, tag, s, 0, t3);
    push(t3, d, {tag, "_t3ill"}, 14'h0, 16'h0, 16'h0, 5'd0,
         1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(t3 + 1, d, {tag, "_idle"});
  endtask

  // ---------------- monitor ----------------
  logic [54:0] act0, act8, act;
  logic        busy_any0, busy_any8;

  always @(negedge Clock) begin
    act0 = {PCout0, MARin0, IncPC0, Zin0, Zlowout0, Zhighout0, PCin0, Read0,
            MDRin0, MDRout0, IRin0, Yin0, LOin0, HIin0, regout0, regin0,
            operation0, busy0, done0, illegal0, timeout0};
    act8 = {PCout8, MARin8, IncPC8, Zin8, Zlowout8, Zhighout8, PCin8, Read8,
            MDRin8, MDRout8, IRin8, Yin8, LOin8, HIin8, 8'h0, regout8,
            8'h0, regin8, operation8, busy8, done8, illegal8, timeout8};
    busy_any0 = busy0 | done0 | illegal0 | timeout0;
    busy_any8 = busy8 | done8 | illegal8 | timeout8;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
               exp_tag_q[0], exp_cyc_q[0], cyc);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      void'(exp_dut_q.pop_front());
      void'(exp_tag_q.pop_front());
    end
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      act = (exp_dut_q[0] == 0) ? act0 : act8;
      n_checks++;
      if (act === exp_q[0]) n_pass++;
      else $display("FAIL %s cyc %0d: actual %h required %h",
                    exp_tag_q[0], cyc, act, exp_q[0]);
      if ((exp_dut_q[0] == 0 && busy_any8) || (exp_dut_q[0] != 0 && busy_any0)) begin
        n_checks++;
        $display("FAIL idle_instance cyc %0d: dut0 act %h dut8 act %h",
                 cyc, act0, act8);
      end
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      void'(exp_dut_q.pop_front());
      void'(exp_tag_q.pop_front());
    end else if (busy_any0 || busy_any8) begin
      n_checks++;
      $display("FAIL unexpected_activity cyc %0d: dut0 %h dut8 %h required idle",
               cyc, act0, act8);
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge: start is sampled at the next edge (cycle S = cyc+1
  // at entry). mem_rdy is held low for `waits` T1 cycles, then raised.
  task automatic go(input int d, input logic [31:0] irv, input int waits);
    ir      = irv;
    mem_rdy = 1'b1;
    if (d == 0) start = 1'b1;
    else        start8 = 1'b1;
    @(negedge Clock);
    start  = 1'b0;
    start8 = 1'b0;
    @(negedge Clock);
    if (waits > 0) begin
      mem_rdy = 1'b0;
      repeat (waits) @(negedge Clock);
      mem_rdy = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, dc, dc2, t3;
    n_checks = 0;
    n_pass   = 0;
    clear    = 1'b0;
    start    = 1'b0;
    start8   = 1'b0;
    mem_rdy  = 1'b0;
    ir       = 32'h0;
    repeat (2) @(negedge Clock);

    // Reset: start and mem_rdy ignored while clear=0
    start   = 1'b1;
    start8  = 1'b1;
    mem_rdy = 1'b1;
    push_idle(cyc + 1, 0, "reset0_a");
    push_idle(cyc + 2, 1, "reset8");
    push_idle(cyc + 3, 0, "reset0_b");
    repeat (3) @(negedge Clock);
    start  = 1'b0;
    start8 = 1'b0;
    clear  = 1'b1;
    repeat (2) @(negedge Clock);

    // and R1,R2,R3 (0x28918000): done at cycle 7
    s = cyc + 1;
    push_txn(0, "and", s, BIN, 1, 2, 3, 5'd5, 0, dc);
    go(0, 32'h28918000, 0);
    repeat (dc - cyc + 2) @(negedge Clock);

    // mul R4,R5 (0x78228000): LO/HI write-back, done at cycle 8
    s = cyc + 1;
    push_txn(0, "mul", s, HILO, 0, 4, 5, 5'd15, 0, dc);
    go(0, 32'h78228000, 0);
    repeat (dc - cyc + 2) @(negedge Clock);

    // neg R6,R7 (opcode 17, Ra=6, Rb=7 -> 0x8B380000): T4 skipped, cycle 6
    s = cyc + 1;
    push_txn(0, "neg", s, UN, 6, 7, 0, 5'd17, 0, dc);
    go(0, 32'h8B380000, 0);
    repeat (dc - cyc + 2) @(negedge Clock);

    // and with 3 memory wait cycles: T1 lasts 4, done at cycle 10
    s = cyc + 1;
    push_txn(0, "and_wait3", s, BIN, 1, 2, 3, 5'd5, 3, dc);
    go(0, 32'h28918000, 3);
    repeat (dc - cyc + 2) @(negedge Clock);

    // mem_rdy stuck low: 15 T1 cycles, then timeout pulse in IDLE
    s = cyc + 1;
    push(s, 0, "tmo_t0", S_PCOUT | S_MARIN | S_INCPC | S_ZIN,
         16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++)
      push(s + k, 0, "tmo_t1", S_ZLOW | S_PCIN | S_READ | S_MDRIN,
           16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(s + 16, 0, "tmo_pulse", 14'h0, 16'h0, 16'h0, 5'd0,
         1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(s + 17, 0, "tmo_after");
    go(0, 32'h28918000, 15);
    repeat (s + 19 - cyc) @(negedge Clock);

    // opcode 31: illegal in T3, nothing else
    s = cyc + 1;
    push_illegal(0, "opc31", s);
    go(0, 32'hF8000000, 0);
    repeat (6) @(negedge Clock);

    // clear low for one cycle during T4
    s = cyc + 1;
    push_front(0, "clr", s, 0, t3);
    push(t3, 0, "clr_t3", S_YIN, 16'h0004, 16'h0, 5'd0,
         1'b1, 1'b0, 1'b0, 1'b0);
    push(t3 + 1, 0, "clr_t4", S_ZIN, 16'h0008, 16'h0, 5'd5,
         1'b1, 1'b0, 1'b0, 1'b0);
    push_idle(t3 + 2, 0, "clr_idle_a");
    push_idle(t3 + 3, 0, "clr_idle_b");
    go(0, 32'h28918000, 0);
    repeat (t3 + 1 - cyc) @(negedge Clock);
    clear = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    repeat (4) @(negedge Clock);

    // ror R15,R14,R13 (0x57F68000) with start held: DONE goes straight to T0
    s = cyc + 1;
    push_txn(0, "b2b_1", s, BIN, 15, 14, 13, 5'd10, 0, dc);
    push_txn(0, "b2b_2", dc + 1, BIN, 15, 14, 13, 5'd10, 0, dc2);
    ir      = 32'h57F68000;
    mem_rdy = 1'b1;
    start   = 1'b1;
    repeat (dc + 1 - cyc) @(negedge Clock);
    start = 1'b0;
    repeat (dc2 - cyc + 2) @(negedge Clock);

    // NREGS=8: add R9,R2,R3 (0x1C918000) is out of range
    s = cyc + 1;
    push_illegal(1, "range_r9", s);
    go(1, 32'h1C918000, 0);
    repeat (6) @(negedge Clock);

    // HILO_EN=0: div R1,R2 (0x80090000) is rejected
    s = cyc + 1;
    push_illegal(1, "div_nohilo", s);
    go(1, 32'h80090000, 0);
    repeat (6) @(negedge Clock);

    // NREGS=8: and R1,R2,R3 is legal
    s = cyc + 1;
    push_txn(1, "and8", s, BIN, 1, 2, 3, 5'd5, 0, dc);
    go(1, 32'h28918000, 0);
    repeat (dc - cyc + 3) @(negedge Clock);

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover_expectations: actual %0d pending required 0",
               exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtype_sequencer.md
RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, giving the number of implemented registers (2..16).
REQ-002 The block SHALL have parameter WAIT_MAX, default 15, giving the maximum number of T1 memory wait cycles before timeout.
REQ-003 The block SHALL have parameter HILO_EN, default 1; when 1, mul/div are supported; when 0, they are illegal.
REQ-004 Port list (name, direction, width, meaning):
- Clock  in  1  single clock; all state changes on its rising edge.
- clear  in  1  reset, synchronous, active-low.
- start  in  1  request to run one instruction.
- ir  in  32  datapath IR contents.
- mem_rdy  in  1  memory read data valid.
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, LOin, HIin  out  1 each  datapath strobes.
- regout  out  NREGS  one-hot register-to-bus enable.
- regin  out  NREGS  one-hot bus-to-register enable.
- operation  out  5  ALU opcode; 0 when idle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle bad-instruction pulse.
- timeout  out  1  one-cycle memory-timeout pulse.

Function
REQ-005 IR fields SHALL be: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-006 Opcode classes SHALL be as follows; any other opcode is illegal.
- Binary: add=3, sub=4, and=5, or=6, shr=7, shra=8, shl=9, ror=10, rol=11.
- HILO: mul=15, div=16.
- Unary: neg=17, not=18.
REQ-007 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; all outputs are Moore-decoded from the state register and ir.
REQ-008 IDLE: start=1 SHALL move to T0 on the next edge; all strobes are 0.
REQ-009 T0 SHALL assert PCout, MARin, IncPC and Zin, then move to T1.
REQ-010 T1 SHALL assert Zlowout, PCin, Read and MDRin.
- It moves to T2 when mem_rdy=1.
- Otherwise it stays in T1 with the strobes held.
REQ-011 The wait counter SHALL clear on entry to T1.
- After WAIT_MAX consecutive cycles with mem_rdy=0 in T1, the block pulses timeout and goes to IDLE.
- No regin, LOin or HIin is asserted in that case.
REQ-012 T2 SHALL assert MDRout and IRin; ir is required stable from T3 until DONE.
REQ-013 T3 SHALL check the instruction before any register strobe is asserted.
- Illegal means: bad opcode, any used register index >= NREGS, or mul/div with HILO_EN=0.
- On illegal, T3 asserts only illegal for that cycle, then goes to IDLE.
REQ-014 T3 for the binary and HILO classes SHALL assert regout[Rb] and Yin, then move to T4.
REQ-015 T3 for the unary class SHALL assert regout[Rb], operation=opcode and Zin, then move to T5 (T4 skipped).
REQ-016 T4 SHALL assert regout[Rc], operation=opcode and Zin, then move to T5.
REQ-017 T5 SHALL assert Zlowout plus a class-dependent strobe.
- Binary/unary: regin[Ra], then move to DONE.
- HILO: LOin, then move to T6.
REQ-018 T6 SHALL assert Zhighout and HIin, then move to DONE.
REQ-019 DONE SHALL pulse done for one cycle.
- It moves to T0 if start=1 (back-to-back, no IDLE cycle), else to IDLE.
REQ-020 start SHALL be ignored while busy=1, except in DONE.
REQ-021 Latency with mem_rdy=1 SHALL be as follows (counted in cycles after the start-sampling edge); each T1 wait cycle adds 1.
- Binary: done at cycle 7.
- Unary: done at cycle 6.
- HILO: done at cycle 8.
REQ-022 At most one bit of regout and at most one bit of regin SHALL be high in any cycle.

Reset
REQ-023 clear=0 at a rising edge SHALL force IDLE in any state, including mid-instruction.
- All outputs become 0 and the wait counter clears.
- No pending regin, LOin or HIin is issued.
REQ-024 While clear=0, the block SHALL ignore start and mem_rdy.

Verification
REQ-025 and case: ir=0x28918000, mem_rdy=1, start pulse -> the bench checks:
- T3: regout[2] with Yin.
- T4: regout[3], operation=5, Zin.
- T5: regin[1] with Zlowout.
- done at cycle 7.
REQ-026 mul case: ir=0x78228000, HILO_EN=1 -> the bench checks:
- T3: regout[4].
- T4: regout[5], operation=15.
- T5: LOin.
- T6: HIin with Zhighout.
- done at cycle 8.
- regin stays 0 throughout.
REQ-027 Memory wait case: mem_rdy=0 for 3 cycles in T1 -> T1 lasts 4 cycles and done is at cycle 10.
- With mem_rdy stuck at 0: timeout pulses after 15 wait cycles, then IDLE, and regin stays 0.
REQ-028 Illegal opcode case: opcode=31 -> illegal pulses in the T3 cycle, then IDLE, with no regout, regin or Zin in T3.
REQ-029 Register range case: NREGS=8, ir=0x1C918000 (add R9,R2,R3) -> illegal pulses in T3 and no register strobe is asserted.
REQ-030 Reset and back-to-back cases:
- clear=0 for one cycle during T4 -> next cycle IDLE, all outputs 0, busy=0.
- start held high -> DONE goes directly to T0.
